// File: rtl/keymatrix_scan_8x8.sv
// keymatrix_scan_8x8: 8x8 key matrix row scanner with
// frame-level debounce feeding the 64-bit matrix datapath.
module keymatrix_scan_8x8 #(
  parameter int SETTLE_CYCLES  = 64,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  column,
  output logic [7:0]  row,
  output logic [63:0] data,
  output logic        changed,
  output logic        frame_done
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  DB          = 8'(DEBOUNCE_SCANS);

  state_t      state;
  logic [7:0]  col_m;
  logic [7:0]  col_s;
  logic [2:0]  idx;
  logic [2:0]  idx_nxt;
  logic [15:0] settle;
  logic [55:0] raw;
  logic [63:0] last_frame;
  logic [7:0]  match;

  logic [63:0] frame_nxt;
  logic [7:0]  match_nxt;
  logic        publish;

  assign idx_nxt = idx + 3'd1;

  // Rows 0..6 shift in from the top, so row 0 lands in raw[7:0].
  always_comb begin
    frame_nxt = {~col_s, raw};
    match_nxt = 8'd1;
    if (frame_nxt == last_frame) begin
      match_nxt = (match >= DB) ? DB : match + 8'd1;
    end
    publish = (match_nxt >= DB) && (frame_nxt != data);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      row        <= 8'hFF;
      data       <= '0;
      changed    <= 1'b0;
      frame_done <= 1'b0;
      idx        <= '0;
      settle     <= '0;
      raw        <= '0;
      last_frame <= '0;
      match      <= '0;
      col_m      <= 8'hFF;
      col_s      <= 8'hFF;
    end else begin
      col_m      <= column;
      col_s      <= col_m;
      changed    <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            state  <= SCAN;
            idx    <= '0;
            settle <= '0;
            row    <= 8'hFE;
          end
        end
        SCAN: begin
          if (settle == SETTLE_LAST) begin
            settle <= '0;
            idx    <= idx_nxt;
            raw    <= {~col_s, raw[55:8]};
            row    <= ~(8'd1 << idx_nxt);
            if (idx == 3'd7) begin
              match      <= match_nxt;
              last_frame <= frame_nxt;
              frame_done <= 1'b1;
              if (publish) begin
                data    <= frame_nxt;
                changed <= 1'b1;
              end
            end
          end else begin
            settle <= settle + 16'd1;
          end
          // A completing frame above still publishes before parking.
          if (!enable) begin
            state <= IDLE;
            row   <= 8'hFF;
          end
        end
        default: begin
          state <= IDLE;
          row   <= 8'hFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keymatrix_scan_8x8.sv
// tb_keymatrix_scan_8x8: directed bench for the key matrix
// scanner, SETTLE_CYCLES=4 (32-cycle frames).
module tb_keymatrix_scan_8x8;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  column;
  logic [7:0]  row;
  logic [63:0] data;
  logic        changed;
  logic        frame_done;
  logic [63:0] keys;

  logic        reset1;
  logic        enable1;
  logic [7:0]  column1;
  logic [7:0]  row1;
  logic [63:0] data1;
  logic        changed1;
  logic        frame_done1;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int ch_cnt = 0;

  always #5 clock = ~clock;

  // Passive matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    column = 8'hFF;
    for (int r = 0; r < 8; r++) begin
      if (row[r] == 1'b0) column = column & ~keys[8*r +: 8];
    end
  end

  keymatrix_scan_8x8 #(.SETTLE_CYCLES(4), .DEBOUNCE_SCANS(3)) dut (
    .clock(clock), .reset(reset), .enable(enable), .column(column),
    .row(row), .data(data), .changed(changed), .frame_done(frame_done)
  );

  keymatrix_scan_8x8 #(.SETTLE_CYCLES(4), .DEBOUNCE_SCANS(1)) dut1 (
    .clock(clock), .reset(reset1), .enable(enable1), .column(column1),
    .row(row1), .data(data1), .changed(changed1), .frame_done(frame_done1)
  );

  task automatic tick();
    @(negedge clock);
    if (frame_done) fd_cnt++;
    if (changed) ch_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    enable = 1'b1;
    fd_cnt = 0;
    ch_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b0;
    keys = '0;
    tick();
    checks++; if (row !== 8'hFF) begin errors++; $display("FAIL reset_row: got %h exp ff", row); end
    checks++; if (data !== 64'h0) begin errors++; $display("FAIL reset_data: got %h exp 0", data); end
    checks++; if (changed !== 1'b0) begin errors++; $display("FAIL reset_changed: got %b exp 0", changed); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b exp 0", frame_done); end
  endtask

  task automatic test_idle_scan();
    logic [7:0] exp_row;
    keys = '0;
    start();
    for (int r = 0; r < 8; r++) begin
      exp_row = ~(8'd1 << r);
      for (int k = 0; k < 4; k++) begin
        tick();
        checks++;
        if (row !== exp_row) begin
          errors++; $display("FAIL scan_row r%0d k%0d: got %h exp %h", r, k, row, exp_row);
        end
      end
    end
    checks++; if (fd_cnt !== 0) begin errors++; $display("FAIL scan_early_fd: got %0d exp 0", fd_cnt); end
    tick();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL scan_fd1: got %b exp 1", frame_done); end
    ticks(64);
    checks++; if (fd_cnt !== 3) begin errors++; $display("FAIL scan_fd_count: got %0d exp 3", fd_cnt); end
    checks++; if (ch_cnt !== 0) begin errors++; $display("FAIL scan_changed: got %0d exp 0", ch_cnt); end
    checks++; if (data !== 64'h0) begin errors++; $display("FAIL scan_data: got %h exp 0", data); end
  endtask

  task automatic test_hold_key();
    keys = 64'h0000_0000_0020_0000;
    start();
    ticks(96);
    checks++; if (fd_cnt !== 2) begin errors++; $display("FAIL hold_fd2: got %0d exp 2", fd_cnt); end
    checks++; if (ch_cnt !== 0) begin errors++; $display("FAIL hold_early_changed: got %0d exp 0", ch_cnt); end
    checks++; if (data !== 64'h0) begin errors++; $display("FAIL hold_early_data: got %h exp 0", data); end
    tick();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL hold_fd3: got %b exp 1", frame_done); end
    checks++; if (changed !== 1'b1) begin errors++; $display("FAIL hold_changed: got %b exp 1", changed); end
    checks++;
    if (data !== 64'h0000_0000_0020_0000) begin
      errors++; $display("FAIL hold_data: got %h exp 0000000000200000", data);
    end
    ticks(96);
    checks++; if (fd_cnt !== 6) begin errors++; $display("FAIL hold_fd6: got %0d exp 6", fd_cnt); end
    checks++; if (ch_cnt !== 1) begin errors++; $display("FAIL hold_single_pulse: got %0d exp 1", ch_cnt); end
    checks++;
    if (data !== 64'h0000_0000_0020_0000) begin
      errors++; $display("FAIL hold_data_kept: got %h exp 0000000000200000", data);
    end
  endtask

  task automatic test_glitch();
    keys = 64'h1;
    start();
    ticks(65);
    keys = 64'h0;
    ticks(96);
    checks++; if (ch_cnt !== 0) begin errors++; $display("FAIL glitch_changed: got %0d exp 0", ch_cnt); end
    checks++; if (data !== 64'h0) begin errors++; $display("FAIL glitch_data: got %h exp 0", data); end
    keys = 64'h1;
    ticks(95);
    checks++; if (ch_cnt !== 0) begin errors++; $display("FAIL glitch_early: got %0d exp 0", ch_cnt); end
    tick();
    checks++; if (changed !== 1'b1) begin errors++; $display("FAIL glitch_pub_changed: got %b exp 1", changed); end
    checks++; if (data !== 64'h1) begin errors++; $display("FAIL glitch_pub_data: got %h exp 1", data); end
  endtask

  task automatic test_disable();
    ticks(13);
    checks++; if (row !== 8'hF7) begin errors++; $display("FAIL dis_row3: got %h exp f7", row); end
    enable = 1'b0;
    tick();
    checks++; if (row !== 8'hFF) begin errors++; $display("FAIL dis_row_idle: got %h exp ff", row); end
    checks++; if (data !== 64'h1) begin errors++; $display("FAIL dis_data: got %h exp 1", data); end
    fd_cnt = 0;
    ticks(5);
    checks++; if (row !== 8'hFF) begin errors++; $display("FAIL dis_row_parked: got %h exp ff", row); end
    checks++; if (fd_cnt !== 0) begin errors++; $display("FAIL dis_fd_parked: got %0d exp 0", fd_cnt); end
    enable = 1'b1;
    ch_cnt = 0;
    tick();
    checks++; if (row !== 8'hFE) begin errors++; $display("FAIL dis_restart_row: got %h exp fe", row); end
    ticks(31);
    checks++; if (fd_cnt !== 0) begin errors++; $display("FAIL dis_restart_early: got %0d exp 0", fd_cnt); end
    tick();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL dis_restart_fd: got %b exp 1", frame_done); end
    checks++; if (changed !== 1'b0) begin errors++; $display("FAIL dis_restart_changed: got %b exp 0", changed); end
    checks++; if (data !== 64'h1) begin errors++; $display("FAIL dis_restart_data: got %h exp 1", data); end
  endtask

  task automatic test_async_reset();
    keys = 64'h0000_0200_0000_0000;
    start();
    ticks(96);
    checks++; if (ch_cnt !== 0) begin errors++; $display("FAIL ar_early: got %0d exp 0", ch_cnt); end
    tick();
    checks++;
    if (changed !== 1'b1 || data !== 64'h0000_0200_0000_0000) begin
      errors++; $display("FAIL ar_pub: got %b/%h exp 1/0000020000000000", changed, data);
    end
    ticks(22);
    checks++; if (row !== 8'hDF) begin errors++; $display("FAIL ar_row5: got %h exp df", row); end
    #2 reset = 1'b1;
    #1;
    checks++; if (row !== 8'hFF) begin errors++; $display("FAIL ar_row: got %h exp ff", row); end
    checks++; if (data !== 64'h0) begin errors++; $display("FAIL ar_data: got %h exp 0", data); end
    checks++; if (changed !== 1'b0) begin errors++; $display("FAIL ar_changed: got %b exp 0", changed); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL ar_fd: got %b exp 0", frame_done); end
    tick();
    reset = 1'b0;
    fd_cnt = 0;
    ch_cnt = 0;
    ticks(96);
    checks++; if (ch_cnt !== 0) begin errors++; $display("FAIL ar_repub_early: got %0d exp 0", ch_cnt); end
    checks++; if (data !== 64'h0) begin errors++; $display("FAIL ar_repub_data0: got %h exp 0", data); end
    tick();
    checks++;
    if (changed !== 1'b1 || data !== 64'h0000_0200_0000_0000) begin
      errors++; $display("FAIL ar_repub: got %b/%h exp 1/0000020000000000", changed, data);
    end
  endtask

  task automatic test_debounce_one();
    @(negedge clock);
    reset1 = 1'b0;
    enable1 = 1'b1;
    @(negedge clock);
    checks++; if (row1 !== 8'hFE) begin errors++; $display("FAIL db1_row0: got %h exp fe", row1); end
    for (int i = 0; i < 31; i++) @(negedge clock);
    checks++; if (frame_done1 !== 1'b0 || data1 !== 64'h0) begin
      errors++; $display("FAIL db1_early: got %b/%h exp 0/0", frame_done1, data1);
    end
    @(negedge clock);
    checks++; if (frame_done1 !== 1'b1) begin errors++; $display("FAIL db1_fd: got %b exp 1", frame_done1); end
    checks++; if (changed1 !== 1'b1) begin errors++; $display("FAIL db1_changed: got %b exp 1", changed1); end
    checks++;
    if (data1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL db1_data: got %h exp ffffffffffffffff", data1);
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    keys = '0;
    reset1 = 1'b1;
    enable1 = 1'b0;
    column1 = 8'h00;
    test_reset();
    test_idle_scan();
    test_hold_key();
    test_glitch();
    test_disable();
    test_async_reset();
    test_debounce_one();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
